// File: rtl/serial_subtractor_pkg.sv
// Shared types and sizing helpers for the digit-serial subtractor.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    function automatic int unsigned ndig(int unsigned n, int unsigned digit);
        return n / digit;
    endfunction

    // Digit counter needs at least one bit even for a single-digit build.
    function automatic int unsigned cnt_w(int unsigned nd);
        return (nd > 1) ? $clog2(nd) : 1;
    endfunction

endpackage

// File: rtl/serial_subtractor_digit.sv
// Combinational DIGIT-bit borrow-ripple subtractor: d = a_d - b_d - bin.
module digit_subtractor #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a_d,
    input  logic [DIGIT-1:0] b_d,
    input  logic             bin,
    output logic [DIGIT-1:0] d,
    output logic             bout
);

    always_comb begin : ripple
        logic br;
        br = bin;
        d  = '0;
        for (int unsigned i = 0; i < DIGIT; i++) begin
            d[i] = a_d[i] ^ b_d[i] ^ br;
            br   = (~a_d[i] & b_d[i]) | (~(a_d[i] ^ b_d[i]) & br);
        end
        bout = br;
    end

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle N-bit subtractor, DIGIT bits per clock, valid/ready on both sides.
// Optional signed-overflow output enabled by defining SUB_OVF_EN.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int N     = 16,
    parameter int DIGIT = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         Bin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] y,
    output logic         Bout
`ifdef SUB_OVF_EN
    ,
    output logic         ovf
`endif
);

    localparam int unsigned NDIG = ndig(N, DIGIT);
    localparam int unsigned CW   = cnt_w(NDIG);

    if (DIGIT < 1 || (N % DIGIT) != 0) begin : g_bad_digit
        $error("serial_subtractor: DIGIT must divide N");
    end

    state_t          state, state_n;
    logic [CW-1:0]   cnt;
    logic [N-1:0]    a_r, b_r;
    logic            br;
    logic [DIGIT-1:0] ad, bd, dd;
    logic            dbo;
    logic            last;

    assign ad   = a_r[cnt*DIGIT +: DIGIT];
    assign bd   = b_r[cnt*DIGIT +: DIGIT];
    assign last = (cnt == CW'(NDIG - 1));

    digit_subtractor #(.DIGIT(DIGIT)) u_digit (
        .a_d  (ad),
        .b_d  (bd),
        .bin  (br),
        .d    (dd),
        .bout (dbo)
    );

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (in_valid && in_ready) state_n = RUN;
            RUN:     if (last) state_n = DONE;
            DONE:    if (out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Handshake outputs are flopped from the next state so they never glitch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state     <= state_n;
            in_ready  <= (state_n == IDLE);
            out_valid <= (state_n == DONE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            br   <= 1'b0;
            a_r  <= '0;
            b_r  <= '0;
            y    <= '0;
            Bout <= 1'b0;
`ifdef SUB_OVF_EN
            ovf  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_r <= a;
                        b_r <= b;
                        br  <= Bin;
                        cnt <= '0;
                    end
                end
                RUN: begin
                    y[cnt*DIGIT +: DIGIT] <= dd;
                    br  <= dbo;
                    cnt <= cnt + CW'(1);
                    if (last) begin
                        cnt  <= '0;
                        Bout <= dbo;
`ifdef SUB_OVF_EN
                        // y's MSB is being written this edge, so take it from the digit result.
                        ovf  <= (a_r[N-1] ^ b_r[N-1]) & (dd[DIGIT-1] ^ a_r[N-1]);
`endif
                    end
                end
                DONE: begin
`ifdef SUB_OVF_EN
                    if (out_ready) ovf <= 1'b0;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule
